sd_init_sequencer: RTL and testbench
====================================

// Module: sd_init_sequencer
// PURPOSE
//  Upstream command source for the SPI master: drives the microSD SPI-mode power-up
//  sequence (CMD0, CMD8, CMD55/ACMD41 loop, optional CMD16) as 48-bit command frames.
//  Per command: one transfer handshake with the SPI master, then evaluate its R1 byte.
//  Reports ready/error to the boot controller, which then owns block read/write traffic.
// PARAMETERS
//  POWERUP_CYCLES  16'd1000  clocks waited after start before CMD0 (card Vdd settle)
//  ACMD41_RETRIES  8'd100    max CMD55+ACMD41 pairs before giving up
//  CMD_TIMEOUT     20'hFFFFF clocks allowed per command handshake (issue to done)
// PORTS
//  sdinit_clk_i      in   1   system clock, same domain as the SPI master
//  sdinit_rst_n_i    in   1   asynchronous active-low reset
//  sdinit_start_i    in   1   1-cycle pulse: begin/restart initialisation
//  spi_doneflag_i    in   1   SPI master done flag (0 while transferring, 1 when idle)
//  R1_i              in   8   R1 response captured by the SPI master
//  spi_data_o        out  48  command frame {cmd, arg[31:0], crc7|1}
//  spi_operation_o   out  1   transfer request to SPI master
//  spi_protocole_o   out  1   constant 0 (microSD)
//  spi_fbo_o         out  1   constant 1 (MSB first)
//  spi_microSDwr_o   out  1   constant 0 (command-only transfers)
//  spi_microSDrd_o   out  1   constant 0
//  sdinit_busy_o     out  1   1 from accepted start until READY or ERR
//  sdinit_ready_o    out  1   card initialised, level until next start/reset
//  sdinit_error_o    out  1   init failed, level until next start/reset
//  sdinit_errcode_o  out  3   failure cause, valid while sdinit_error_o=1
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; spi_data_o=48'hFFFFFFFFFFFF; spi_operation_o=0;
//   busy/ready/error=0; errcode=0; all counters 0. Reset mid-sequence aborts at once.
//  States: IDLE, PWRUP, ISSUE, ACCEPT, WAIT, EVAL, READY, ERR; cmd_sel register picks frame.
//  IDLE/READY/ERR + start -> PWRUP; clear ready/error/errcode, set busy. start ignored elsewhere.
//  PWRUP: count POWERUP_CYCLES clocks, then cmd_sel=CMD0 -> ISSUE.
//  Frames: CMD0 40_00000000_95; CMD8 48_000001AA_87; CMD55 77_00000000_65;
//   ACMD41 69_40000000_77; CMD16 50_00000200_15. spi_data_o registered, stable ISSUE..EVAL.
//  ISSUE: load frame, assert spi_operation_o, clear watchdog -> ACCEPT.
//  ACCEPT: on spi_doneflag_i=0 deassert spi_operation_o -> WAIT (done-low arm, so the
//   idle-high flag is never mistaken for completion).
//  WAIT: on spi_doneflag_i=1 -> EVAL (R1_i sampled in EVAL, one cycle after done rises).
//  Watchdog: counts in ACCEPT and WAIT; reaching CMD_TIMEOUT -> ERR, code 5, op=0.
//  EVAL per cmd_sel:
//   CMD0: R1=01 -> CMD8; else ERR code 1.
//   CMD8: R1=01 -> CMD55, retry=0; else ERR code 2 (incl. 05: v1 card unsupported).
//   CMD55: R1=01 or 00 -> ACMD41; else ERR code 3.
//   ACMD41: R1=00 -> CMD16 (macro on) or READY; R1=01: retry+1, retry==ACMD41_RETRIES
//    -> ERR code 3, else -> CMD55; other -> ERR code 3.
//   CMD16: R1=00 -> READY; else ERR code 4.
//  READY/ERR: busy=0, spi_operation_o=0, spi_data_o held at last frame.
//  Retry counter 8-bit, saturates at ACMD41_RETRIES; watchdog 20-bit, no wrap.
//  Latency: ISSUE->spi_operation_o high next clock; EVAL->next ISSUE in 1 clock.
// CONFIGURATION
//  SDINIT_BLKLEN_EN defined: after ACMD41 R1=00, issue CMD16 (512-byte blocks),
//   error code 4 possible. Undefined: ACMD41 success -> READY; CMD16 logic and
//   code 4 absent.
// TESTING
//  1 Reset low mid-WAIT -> next clock op=0, busy=0, data=FFFFFFFFFFFF, state IDLE.
//  2 Card model R1: CMD0 01, CMD8 01, ACMD41 01,01,00 -> 3 CMD55/ACMD41 pairs, ready=1,
//    busy=0; with SDINIT_BLKLEN_EN one extra frame 500000020015 before ready.
//  3 CMD8 returns 05 -> error=1, errcode=2, no CMD55 frame ever issued.
//  4 ACMD41 always 01, ACMD41_RETRIES=3 -> exactly 3 pairs, errcode=3.
//  5 Done held 1 (SPI stuck), CMD_TIMEOUT=100 -> error, errcode=5 after 100 clocks; op=0.
//  6 start pulse while busy -> ignored; start after error -> errcode cleared, CMD0 reissued.

Source files
------------

// File: rtl/sd_init_sequencer_if.sv
// SPI-master side of the microSD init sequencer: command frame, transfer
// request, static transfer attributes, and the done flag / R1 byte coming back.
// master modport: the sequencer (command source). slave modport: the SPI master.
interface sd_init_sequencer_if;
   logic [47:0] spi_data_o;
   logic        spi_operation_o;
   logic        spi_protocole_o;
   logic        spi_fbo_o;
   logic        spi_microSDwr_o;
   logic        spi_microSDrd_o;
   logic        spi_doneflag_i;
   logic [7:0]  R1_i;

   modport master (
      output spi_data_o, spi_operation_o, spi_protocole_o, spi_fbo_o,
             spi_microSDwr_o, spi_microSDrd_o,
      input  spi_doneflag_i, R1_i
   );

   modport slave (
      input  spi_data_o, spi_operation_o, spi_protocole_o, spi_fbo_o,
             spi_microSDwr_o, spi_microSDrd_o,
      output spi_doneflag_i, R1_i
   );
endinterface

// File: rtl/sd_init_sequencer.sv
// microSD SPI-mode power-up sequencer: CMD0, CMD8, CMD55/ACMD41 loop and,
// when SDINIT_BLKLEN_EN is defined, CMD16 (512-byte blocks).
// Each command is one handshake with the SPI master followed by an R1 check.
// Error codes: 1 CMD0, 2 CMD8, 3 CMD55/ACMD41, 4 CMD16, 5 handshake timeout.
module sd_init_sequencer #(
   parameter logic [15:0] POWERUP_CYCLES = 16'd1000,
   parameter logic [7:0]  ACMD41_RETRIES = 8'd100,
   parameter logic [19:0] CMD_TIMEOUT    = 20'hFFFFF
) (
   input  logic                       sdinit_clk_i,
   input  logic                       sdinit_rst_n_i,
   input  logic                       sdinit_start_i,
   sd_init_sequencer_if.master        spi,
   output logic                       sdinit_busy_o,
   output logic                       sdinit_ready_o,
   output logic                       sdinit_error_o,
   output logic [2:0]                 sdinit_errcode_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_PWRUP, S_ISSUE, S_ACCEPT, S_WAIT, S_EVAL, S_READY, S_ERR
   } state_t;

`ifdef SDINIT_BLKLEN_EN
   typedef enum logic [2:0] {
      C_CMD0 = 3'd0, C_CMD8 = 3'd1, C_CMD55 = 3'd2, C_ACMD41 = 3'd3, C_CMD16 = 3'd4
   } cmd_t;
`else
   typedef enum logic [2:0] {
      C_CMD0 = 3'd0, C_CMD8 = 3'd1, C_CMD55 = 3'd2, C_ACMD41 = 3'd3
   } cmd_t;
`endif

   localparam logic [47:0] FRAME_IDLE = 48'hFFFF_FFFF_FFFF;

   // Command frame lookup {cmd, arg, crc7|1}.
   function automatic logic [47:0] frame_of(input cmd_t c);
      logic [47:0] f;
      case (c)
         C_CMD0:   f = 48'h40_0000_0000_95;
         C_CMD8:   f = 48'h48_0000_01AA_87;
         C_CMD55:  f = 48'h77_0000_0000_65;
         C_ACMD41: f = 48'h69_4000_0000_77;
`ifdef SDINIT_BLKLEN_EN
         C_CMD16:  f = 48'h50_0000_0200_15;
`endif
         default:  f = FRAME_IDLE;
      endcase
      return f;
   endfunction

   state_t      state_q, state_d;
   cmd_t        cmd_q, cmd_d;
   logic [15:0] pwr_q, pwr_d;
   logic [7:0]  retry_q, retry_d;
   logic [19:0] wdog_q, wdog_d;
   logic [47:0] data_q, data_d;
   logic        op_q, op_d;
   logic        busy_q, busy_d;
   logic        ready_q, ready_d;
   logic        error_q, error_d;
   logic [2:0]  errcode_q, errcode_d;

   logic        fail_s;
   logic [2:0]  fail_code_s;
   logic        done_s;
   logic        wdog_hit_s;
   logic [7:0]  retry_inc_s;

   assign wdog_hit_s  = ({1'b0, wdog_q} + 21'd1) >= {1'b0, CMD_TIMEOUT};
   assign retry_inc_s = (retry_q < ACMD41_RETRIES) ? (retry_q + 8'd1) : retry_q;

   // Next-state and output decode for the init sequence.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      pwr_d       = pwr_q;
      retry_d     = retry_q;
      wdog_d      = wdog_q;
      data_d      = data_q;
      op_d        = op_q;
      busy_d      = busy_q;
      ready_d     = ready_q;
      error_d     = error_q;
      errcode_d   = errcode_q;
      fail_s      = 1'b0;
      fail_code_s = 3'd0;
      done_s      = 1'b0;

      case (state_q)
         S_IDLE, S_READY, S_ERR: begin
            op_d = 1'b0;
            if (sdinit_start_i) begin
               state_d   = S_PWRUP;
               pwr_d     = 16'd0;
               ready_d   = 1'b0;
               error_d   = 1'b0;
               errcode_d = 3'd0;
               busy_d    = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         S_PWRUP: begin
            if (({1'b0, pwr_q} + 17'd1) >= {1'b0, POWERUP_CYCLES}) begin
               cmd_d   = C_CMD0;
               state_d = S_ISSUE;
            end else begin
               pwr_d = pwr_q + 16'd1;
            end
         end
         S_ISSUE: begin
            data_d  = frame_of(cmd_q);
            op_d    = 1'b1;
            wdog_d  = 20'd0;
            state_d = S_ACCEPT;
         end
         S_ACCEPT: begin
            // Wait for done to drop first so the idle-high flag is not taken as completion.
            if (!spi.spi_doneflag_i) begin
               op_d    = 1'b0;
               state_d = S_WAIT;
            end else if (wdog_hit_s) begin
               fail_s      = 1'b1;
               fail_code_s = 3'd5;
            end else begin
               wdog_d = wdog_q + 20'd1;
            end
         end
         S_WAIT: begin
            if (spi.spi_doneflag_i) begin
               state_d = S_EVAL;
            end else if (wdog_hit_s) begin
               fail_s      = 1'b1;
               fail_code_s = 3'd5;
            end else begin
               wdog_d = wdog_q + 20'd1;
            end
         end
         S_EVAL: begin
            case (cmd_q)
               C_CMD0: begin
                  if (spi.R1_i == 8'h01) begin
                     cmd_d = C_CMD8; state_d = S_ISSUE;
                  end else begin
                     fail_s = 1'b1; fail_code_s = 3'd1;
                  end
               end
               C_CMD8: begin
                  // 05 (illegal command) means a v1 card, which is not supported.
                  if (spi.R1_i == 8'h01) begin
                     cmd_d = C_CMD55; retry_d = 8'd0; state_d = S_ISSUE;
                  end else begin
                     fail_s = 1'b1; fail_code_s = 3'd2;
                  end
               end
               C_CMD55: begin
                  if ((spi.R1_i == 8'h01) || (spi.R1_i == 8'h00)) begin
                     cmd_d = C_ACMD41; state_d = S_ISSUE;
                  end else begin
                     fail_s = 1'b1; fail_code_s = 3'd3;
                  end
               end
               C_ACMD41: begin
                  if (spi.R1_i == 8'h00) begin
`ifdef SDINIT_BLKLEN_EN
                     cmd_d = C_CMD16; state_d = S_ISSUE;
`else
                     done_s = 1'b1;
`endif
                  end else if (spi.R1_i == 8'h01) begin
                     retry_d = retry_inc_s;
                     if (retry_inc_s == ACMD41_RETRIES) begin
                        fail_s = 1'b1; fail_code_s = 3'd3;
                     end else begin
                        cmd_d = C_CMD55; state_d = S_ISSUE;
                     end
                  end else begin
                     fail_s = 1'b1; fail_code_s = 3'd3;
                  end
               end
`ifdef SDINIT_BLKLEN_EN
               C_CMD16: begin
                  if (spi.R1_i == 8'h00) begin
                     done_s = 1'b1;
                  end else begin
                     fail_s = 1'b1; fail_code_s = 3'd4;
                  end
               end
`endif
               default: begin
                  // Unreachable command selector: stop with a distinct code.
                  fail_s = 1'b1; fail_code_s = 3'd7;
               end
            endcase
         end
         default: begin
            state_d = S_IDLE;
            op_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      if (fail_s) begin
         state_d   = S_ERR;
         error_d   = 1'b1;
         errcode_d = fail_code_s;
         busy_d    = 1'b0;
         op_d      = 1'b0;
      end else if (done_s) begin
         state_d = S_READY;
         ready_d = 1'b1;
         busy_d  = 1'b0;
         op_d    = 1'b0;
      end else begin
         busy_d = busy_d;
      end
   end

   // State, counters and registered outputs; reset aborts any sequence at once.
   always_ff @(posedge sdinit_clk_i or negedge sdinit_rst_n_i) begin
      if (!sdinit_rst_n_i) begin
         state_q   <= S_IDLE;
         cmd_q     <= C_CMD0;
         pwr_q     <= 16'd0;
         retry_q   <= 8'd0;
         wdog_q    <= 20'd0;
         data_q    <= FRAME_IDLE;
         op_q      <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         error_q   <= 1'b0;
         errcode_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         pwr_q     <= pwr_d;
         retry_q   <= retry_d;
         wdog_q    <= wdog_d;
         data_q    <= data_d;
         op_q      <= op_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         error_q   <= error_d;
         errcode_q <= errcode_d;
      end
   end

   assign spi.spi_data_o      = data_q;
   assign spi.spi_operation_o = op_q;
   assign spi.spi_protocole_o = 1'b0;
   assign spi.spi_fbo_o       = 1'b1;
   assign spi.spi_microSDwr_o = 1'b0;
   assign spi.spi_microSDrd_o = 1'b0;
   assign sdinit_busy_o       = busy_q;
   assign sdinit_ready_o      = ready_q;
   assign sdinit_error_o      = error_q;
   assign sdinit_errcode_o    = errcode_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer with a small card model driving the
// SPI done flag and R1 byte. Honours SDINIT_BLKLEN_EN for the CMD16 step.
module tb_sd_init_sequencer;
   localparam logic [47:0] F_IDLE   = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] F_CMD0   = 48'h40_0000_0000_95;
   localparam logic [47:0] F_CMD8   = 48'h48_0000_01AA_87;
   localparam logic [47:0] F_CMD55  = 48'h77_0000_0000_65;
   localparam logic [47:0] F_ACMD41 = 48'h69_4000_0000_77;
   localparam logic [47:0] F_CMD16  = 48'h50_0000_0200_15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, ready, error;
   logic [2:0] errcode;
   int         n_assert = 0;
   int         n_fail = 0;

   sd_init_sequencer_if spi_if ();

   sd_init_sequencer #(
      .POWERUP_CYCLES (16'd5),
      .ACMD41_RETRIES (8'd3),
      .CMD_TIMEOUT    (20'd100)
   ) dut (
      .sdinit_clk_i     (clk),
      .sdinit_rst_n_i   (rst_n),
      .sdinit_start_i   (start),
      .spi              (spi_if),
      .sdinit_busy_o    (busy),
      .sdinit_ready_o   (ready),
      .sdinit_error_o   (error),
      .sdinit_errcode_o (errcode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_op(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (spi_if.spi_operation_o === 1'b1) seen = 1'b1;
      end
   endtask

   // Card model: accept one command, check its frame, answer with r1.
   task automatic serve(input string tag, input logic [7:0] r1, input logic [47:0] exp_frame);
      bit seen;
      wait_op(seen);
      check({tag, "_op"}, {47'd0, seen}, 48'd1);
      if (seen) begin
         check(tag, spi_if.spi_data_o, exp_frame);
         spi_if.spi_doneflag_i = 1'b0;
         repeat (3) @(negedge clk);
         spi_if.R1_i = r1;
         spi_if.spi_doneflag_i = 1'b1;
      end
   endtask

   // Count cycles with a transfer request over a window (expect none).
   task automatic quiet(input string tag, input int cycles);
      int ops = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (spi_if.spi_operation_o !== 1'b0) ops++;
      end
      check(tag, 48'(ops), 48'd0);
   endtask

   initial begin
      bit seen;
      int n;
      spi_if.spi_doneflag_i = 1'b1;
      spi_if.R1_i = 8'hFF;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data", spi_if.spi_data_o, F_IDLE);
      check("rst_op", {47'd0, spi_if.spi_operation_o}, 48'd0);
      check("rst_busy", {47'd0, busy}, 48'd0);
      check("rst_ready", {47'd0, ready}, 48'd0);
      check("rst_error", {47'd0, error}, 48'd0);
      check("rst_code", {45'd0, errcode}, 48'd0);
      check("const_fbo", {47'd0, spi_if.spi_fbo_o}, 48'd1);
      check("const_proto", {47'd0, spi_if.spi_protocole_o}, 48'd0);
      rst_n = 1'b1;
      quiet("idle_no_op", 10);

      // Normal init: ACMD41 answers 01,01,00; a start while busy is ignored
      pulse_start();
      check("busy_after_start", {47'd0, busy}, 48'd1);
      serve("n_cmd0", 8'h01, F_CMD0);
      pulse_start();
      serve("n_cmd8", 8'h01, F_CMD8);
      serve("n_cmd55_1", 8'h01, F_CMD55);
      serve("n_acmd41_1", 8'h01, F_ACMD41);
      serve("n_cmd55_2", 8'h00, F_CMD55);
      serve("n_acmd41_2", 8'h01, F_ACMD41);
      serve("n_cmd55_3", 8'h01, F_CMD55);
      serve("n_acmd41_3", 8'h00, F_ACMD41);
`ifdef SDINIT_BLKLEN_EN
      serve("n_cmd16", 8'h00, F_CMD16);
`endif
      quiet("n_no_more_ops", 20);
      check("n_ready", {47'd0, ready}, 48'd1);
      check("n_busy", {47'd0, busy}, 48'd0);
      check("n_error", {47'd0, error}, 48'd0);
`ifdef SDINIT_BLKLEN_EN
      check("n_data_held", spi_if.spi_data_o, F_CMD16);
`else
      check("n_data_held", spi_if.spi_data_o, F_ACMD41);
`endif

      // CMD8 answers 05: v1 card rejected, no CMD55 ever issued
      pulse_start();
      check("v1_ready_cleared", {47'd0, ready}, 48'd0);
      serve("v1_cmd0", 8'h01, F_CMD0);
      serve("v1_cmd8", 8'h05, F_CMD8);
      quiet("v1_no_cmd55", 40);
      check("v1_error", {47'd0, error}, 48'd1);
      check("v1_code", {45'd0, errcode}, 48'd2);
      check("v1_busy", {47'd0, busy}, 48'd0);
      check("v1_data_held", spi_if.spi_data_o, F_CMD8);

      // Restart after error, then ACMD41 never leaves idle: exactly 3 pairs
      pulse_start();
      check("rs_error_clr", {47'd0, error}, 48'd0);
      check("rs_code_clr", {45'd0, errcode}, 48'd0);
      check("rs_busy", {47'd0, busy}, 48'd1);
      serve("rt_cmd0", 8'h01, F_CMD0);
      serve("rt_cmd8", 8'h01, F_CMD8);
      for (int p = 0; p < 3; p++) begin
         serve("rt_cmd55", 8'h01, F_CMD55);
         serve("rt_acmd41", 8'h01, F_ACMD41);
      end
      quiet("rt_no_4th_pair", 40);
      check("rt_error", {47'd0, error}, 48'd1);
      check("rt_code", {45'd0, errcode}, 48'd3);

      // SPI stuck with done high: watchdog fires 100 clocks after the request
      pulse_start();
      wait_op(seen);
      check("to_op_seen", {47'd0, seen}, 48'd1);
      check("to_frame", spi_if.spi_data_o, F_CMD0);
      n = 0;
      for (int i = 0; i < 300 && error !== 1'b1; i++) begin
         @(negedge clk);
         n++;
      end
      check("to_cycles", 48'(n), 48'd100);
      check("to_error", {47'd0, error}, 48'd1);
      check("to_code", {45'd0, errcode}, 48'd5);
      check("to_op", {47'd0, spi_if.spi_operation_o}, 48'd0);

      // Reset asserted while waiting for done aborts everything
      pulse_start();
      wait_op(seen);
      check("mr_op_seen", {47'd0, seen}, 48'd1);
      spi_if.spi_doneflag_i = 1'b0;
      repeat (2) @(negedge clk);
      check("mr_busy_before", {47'd0, busy}, 48'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mr_op", {47'd0, spi_if.spi_operation_o}, 48'd0);
      check("mr_busy", {47'd0, busy}, 48'd0);
      check("mr_data", spi_if.spi_data_o, F_IDLE);
      check("mr_error", {47'd0, error}, 48'd0);
      check("mr_code", {45'd0, errcode}, 48'd0);
      spi_if.spi_doneflag_i = 1'b1;
      rst_n = 1'b1;
      quiet("mr_stays_idle", 20);
      check("mr_busy_idle", {47'd0, busy}, 48'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
